// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the flash sample reader and its address generator.
package flash_reader_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam logic [3:0]  BYTEEN_ALL = 4'b1111;
  localparam logic        DIR_FWD    = 1'b0;
  localparam logic        DIR_BWD    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DATA,
    ST_OUT_A,
    ST_OUT_B,
    ST_DONE
  } state_t;

  function automatic logic [SAMPLE_W-1:0] pick_half(input logic [31:0] word, input logic upper);
    return upper ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/flash_addr_gen.sv
// Flash word-address register: start-address reload on restart, wrapping up/down step per word.
module flash_addr_gen
  import flash_reader_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 23,
  parameter logic [ADDR_W-1:0]    START_ADDR = '0,
  parameter logic [ADDR_W-1:0]    END_ADDR   = 23'h07FFFF
) (
  input  logic              inclk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic              restart,
  input  logic              direction,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] ONE = 1;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] dir_start;
  logic [ADDR_W-1:0] stepped;

  assign dir_start = (direction == DIR_BWD) ? END_ADDR : START_ADDR;

  always_comb begin
    stepped = addr_q;
    if (direction == DIR_FWD)
      stepped = (addr_q == END_ADDR) ? START_ADDR : addr_q + ONE;
    else
      stepped = (addr_q == START_ADDR) ? END_ADDR : addr_q - ONE;
  end

  // restart outranks the wrap/step when a word completes
  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n)
      addr_q <= START_ADDR;
    else if (load || (step && restart))
      addr_q <= dir_start;
    else if (step)
      addr_q <= stepped;
  end

  assign addr = addr_q;

endmodule

// File: rtl/flash_sample_reader.sv
// Reads 32-bit flash words over Avalon-MM and plays them as two 16-bit samples paced by sample_tick.
// Optional: PAUSE_MUTE_EN forces audio_data to zero while start_read_flash is low.
module flash_sample_reader
  import flash_reader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic                inclk,
  input  logic                reset_n,
  input  logic                start_read_flash,
  input  logic                direction,
  input  logic                restart,
  input  logic                sample_tick,
  output logic                flash_mem_read,
  output logic [ADDR_W-1:0]   flash_mem_address,
  output logic [3:0]          flash_mem_byteenable,
  input  logic                flash_mem_waitrequest,
  input  logic [31:0]         flash_mem_readdata,
  input  logic                flash_mem_readdatavalid,
  output logic [SAMPLE_W-1:0] audio_data,
  output logic                flash_read_finished
);

  state_t state_q, state_d;

  logic [31:0]         word_q;
  logic                dir_q;
  logic [SAMPLE_W-1:0] audio_q;
  logic                latch_word;
  logic                emit_a;
  logic                emit_b;
  logic                addr_load;
  logic                addr_step;

  flash_addr_gen #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_addr_gen (
    .inclk     (inclk),
    .reset_n   (reset_n),
    .load      (addr_load),
    .step      (addr_step),
    .restart   (restart),
    .direction (direction),
    .addr      (flash_mem_address)
  );

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    flash_mem_read      = 1'b0;
    flash_read_finished = 1'b0;
    latch_word          = 1'b0;
    emit_a              = 1'b0;
    emit_b              = 1'b0;
    addr_load           = 1'b0;
    addr_step           = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_read_flash) begin
          addr_load = restart;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        flash_mem_read = 1'b1;
        if (!flash_mem_waitrequest)
          state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          latch_word = 1'b1;
          state_d    = ST_OUT_A;
        end
      end
      // pause only freezes the sample phases; an issued Avalon read always completes
      ST_OUT_A: begin
        if (start_read_flash && sample_tick) begin
          emit_a  = 1'b1;
          state_d = ST_OUT_B;
        end
      end
      ST_OUT_B: begin
        if (start_read_flash && sample_tick) begin
          emit_b  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        flash_read_finished = 1'b1;
        addr_step           = 1'b1;
        state_d             = start_read_flash ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      word_q  <= '0;
      dir_q   <= DIR_FWD;
      audio_q <= '0;
    end else begin
      if (latch_word) begin
        word_q <= flash_mem_readdata;
        dir_q  <= direction;
      end
      if (emit_a)
        audio_q <= pick_half(word_q, dir_q == DIR_BWD);
      else if (emit_b)
        audio_q <= pick_half(word_q, dir_q == DIR_FWD);
    end
  end

  assign flash_mem_byteenable = BYTEEN_ALL;

`ifdef PAUSE_MUTE_EN
  assign audio_data = start_read_flash ? audio_q : '0;
`else
  assign audio_data = audio_q;
`endif

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed and randomized playback checks of flash_sample_reader against an address/sample model.
module tb_flash_sample_reader;

  localparam int unsigned ADDR_W = 23;
  localparam logic [22:0] START  = 23'h000000;
  localparam logic [22:0] LAST   = 23'h07FFFF;

  logic        inclk = 1'b0;
  logic        reset_n;
  logic        start_read_flash;
  logic        direction;
  logic        restart;
  logic        sample_tick;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic [15:0] audio_data;
  logic        flash_read_finished;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [15:0] cur_audio;
  logic [22:0] addr;

  flash_sample_reader #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START),
    .END_ADDR   (LAST)
  ) dut (
    .inclk                   (inclk),
    .reset_n                 (reset_n),
    .start_read_flash        (start_read_flash),
    .direction               (direction),
    .restart                 (restart),
    .sample_tick             (sample_tick),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .audio_data              (audio_data),
    .flash_read_finished     (flash_read_finished)
  );

  always #5 inclk = ~inclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge inclk);
    #1;
  endtask

  // Clip address sequencing: restart jumps to the direction's start, otherwise wrap at the ends.
  function automatic logic [22:0] model_next(input logic [22:0] a, input logic dir, input logic rst);
    if (rst) return dir ? LAST : START;
    if (!dir) return (a == LAST) ? START : a + 23'd1;
    return (a == START) ? LAST : a - 23'd1;
  endfunction

  task automatic play_word(input logic [22:0] exp_addr, input logic [31:0] data,
                           input int unsigned waits, input int unsigned lat,
                           input int unsigned pause_ticks, input bit rst_mid,
                           output logic [22:0] next_addr);
    int unsigned n;
    logic [15:0] s1, s2;
    n = 0;
    while (flash_mem_read !== 1'b1 && n < 50) begin
      step_clk();
      n++;
    end
    check("req_seen", {31'd0, flash_mem_read}, 32'd1);
    check("req_addr", {9'd0, flash_mem_address}, {9'd0, exp_addr});
    check("finished_in_req", {31'd0, flash_read_finished}, 32'd0);
    flash_mem_waitrequest = (waits != 0);
    for (int i = 0; i < int'(waits); i++) begin
      step_clk();
      check("stall_read", {31'd0, flash_mem_read}, 32'd1);
      check("stall_addr", {9'd0, flash_mem_address}, {9'd0, exp_addr});
    end
    flash_mem_waitrequest = 1'b0;
    step_clk();
    check("single_request", {31'd0, flash_mem_read}, 32'd0);
    if (rst_mid) restart = 1'b1;
    sample_tick = 1'b1;
    step_clk();
    sample_tick = 1'b0;
    check("tick_dropped", {16'd0, audio_data}, {16'd0, cur_audio});
    for (int i = 0; i < int'(lat); i++) step_clk();
    check("finished_in_wait", {31'd0, flash_read_finished}, 32'd0);
    s1 = direction ? data[31:16] : data[15:0];
    s2 = direction ? data[15:0]  : data[31:16];
    flash_mem_readdata      = data;
    flash_mem_readdatavalid = 1'b1;
    step_clk();
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = $urandom;
    check("hold_before_tick", {16'd0, audio_data}, {16'd0, cur_audio});
    sample_tick = 1'b1;
    step_clk();
    sample_tick = 1'b0;
    cur_audio = s1;
    check("sample_first", {16'd0, audio_data}, {16'd0, s1});
    check("finished_mid", {31'd0, flash_read_finished}, 32'd0);
    if (pause_ticks != 0) begin
      start_read_flash = 1'b0;
      for (int k = 0; k < int'(pause_ticks); k++) begin
        sample_tick = 1'b1;
        step_clk();
        sample_tick = 1'b0;
        step_clk();
`ifdef PAUSE_MUTE_EN
        check("pause_audio", {16'd0, audio_data}, 32'd0);
`else
        check("pause_audio", {16'd0, audio_data}, {16'd0, s1});
`endif
        check("pause_finished", {31'd0, flash_read_finished}, 32'd0);
      end
      start_read_flash = 1'b1;
      step_clk();
      check("resume_audio", {16'd0, audio_data}, {16'd0, s1});
    end
    sample_tick = 1'b1;
    step_clk();
    sample_tick = 1'b0;
    cur_audio = s2;
    check("sample_second", {16'd0, audio_data}, {16'd0, s2});
    check("finished_pulse", {31'd0, flash_read_finished}, 32'd1);
    next_addr = model_next(exp_addr, direction, restart);
    step_clk();
    check("finished_single", {31'd0, flash_read_finished}, 32'd0);
    if (rst_mid) restart = 1'b0;
  endtask

  initial begin
    reset_n                 = 1'b0;
    start_read_flash        = 1'b0;
    direction               = 1'b0;
    restart                 = 1'b0;
    sample_tick             = 1'b0;
    flash_mem_waitrequest   = 1'b0;
    flash_mem_readdata      = '0;
    flash_mem_readdatavalid = 1'b0;
    cur_audio               = '0;
    repeat (3) step_clk();
    check("rst_read", {31'd0, flash_mem_read}, 32'd0);
    check("rst_audio", {16'd0, audio_data}, 32'd0);
    check("rst_finished", {31'd0, flash_read_finished}, 32'd0);
    check("rst_addr", {9'd0, flash_mem_address}, {9'd0, START});
    check("byteenable", {28'd0, flash_mem_byteenable}, 32'hF);
    reset_n = 1'b1;
    repeat (3) step_clk();
    check("idle_no_read", {31'd0, flash_mem_read}, 32'd0);

    start_read_flash = 1'b1;
    play_word(START, 32'hBBBB_AAAA, 0, 0, 0, 1'b0, addr);
    check("fwd_next", {9'd0, addr}, 32'd1);
    play_word(addr, $urandom, 3, 1, 0, 1'b0, addr);
    for (int i = 0; i < 3; i++)
      play_word(addr, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0, addr);

    direction = 1'b1;
    play_word(addr, 32'h2222_1111, 1, 0, 0, 1'b0, addr);
    check("bwd_next", {9'd0, addr}, 32'd4);
    play_word(addr, $urandom, 0, 1, 0, 1'b0, addr);
    play_word(addr, $urandom, 1, 0, 10, 1'b0, addr);
    for (int i = 0; i < 3; i++)
      play_word(addr, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0, addr);
    check("bwd_wrap", {9'd0, addr}, {9'd0, LAST});

    direction = 1'b0;
    play_word(addr, $urandom, 0, 0, 0, 1'b0, addr);
    check("fwd_wrap", {9'd0, addr}, {9'd0, START});

    for (int i = 0; i < 256; i++)
      play_word(addr, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0, addr);
    check("walk_to_100", {9'd0, addr}, 32'h100);
    play_word(addr, $urandom, 0, 1, 0, 1'b1, addr);
    check("restart_next", {9'd0, addr}, {9'd0, START});
    play_word(addr, $urandom, 0, 0, 0, 1'b0, addr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
